// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin N:1 arbiter with payload mux.
// Selection is combinational; the priority pointer, the per-turn credit and
// the grant lock are registered. An input keeps priority for up to its weight
// in consecutive grants before the pointer moves on.
//
// Handshake: req_o is the downstream valid and gnt_i the downstream ready.
// A transfer (hs) happens in a cycle where both are high. While req_o is high
// and gnt_i is low, the selected input is locked (LockIn=1). That input's
// payload and index then stay stable until the transfer. A requester must not
// drop req_i while it is locked.
// The FSM state is visible to checkers as the internal signal fsm_state.
module weighted_rr_arbiter #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter bit          LockIn      = 1'b1,
  localparam int unsigned IdxW       = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NumIn-1:0]             req_i,
  input  logic [NumIn*DataWidth-1:0]   data_i,
  input  logic [NumIn*WeightWidth-1:0] weight_i,
  input  logic                         gnt_i,
  output logic [NumIn-1:0]             gnt_o,
  output logic                         req_o,
  output logic [DataWidth-1:0]         data_o,
  output logic [IdxW-1:0]              idx_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                 fsm_state;
  logic [IdxW-1:0]        ptr;
  logic [WeightWidth-1:0] credit;
  logic [IdxW-1:0]        lock_idx;

  logic                   scan_found;
  logic [IdxW-1:0]        scan_sel;
  logic [IdxW:0]          cand;
  logic                   lock_valid;
  logic                   any_req;
  logic [IdxW-1:0]        sel;
  logic [DataWidth-1:0]   sel_data;
  logic [WeightWidth-1:0] sel_weight;
  logic                   hs;
  logic [WeightWidth-1:0] cb;
  logic [WeightWidth:0]   cb_inc;
  logic [WeightWidth:0]   w_eff;
  logic [IdxW-1:0]        ptr_after;

  // Scan requests starting at ptr, wrapping modulo NumIn.
  always_comb begin
    scan_found = 1'b0;
    scan_sel   = '0;
    cand       = '0;
    for (int i = 0; i < NumIn; i++) begin
      cand = {1'b0, ptr} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumIn)) cand = cand - (IdxW+1)'(NumIn);
      if (!scan_found && req_i[cand[IdxW-1:0]]) begin
        scan_found = 1'b1;
        scan_sel   = cand[IdxW-1:0];
      end
    end
  end

  // The lock holds only while its owner still requests; otherwise fall back to the scan.
  always_comb begin
    lock_valid = (fsm_state == LOCKED) && req_i[lock_idx];
    sel        = lock_valid ? lock_idx : scan_sel;
    any_req    = lock_valid || scan_found;
  end

  // Pick the winner's payload and weight.
  always_comb begin
    sel_data   = '0;
    sel_weight = '0;
    for (int k = 0; k < NumIn; k++) begin
      if (sel == IdxW'(k)) begin
        sel_data   = data_i[k*DataWidth +: DataWidth];
        sel_weight = weight_i[k*WeightWidth +: WeightWidth];
      end
    end
  end

  // Drive the downstream side and the one-hot grant back to the winner.
  always_comb begin
    req_o  = any_req && !flush_i;
    hs     = req_o && gnt_i;
    data_o = any_req ? sel_data : '0;
    idx_o  = any_req ? sel : '0;
    gnt_o  = '0;
    for (int k = 0; k < NumIn; k++) begin
      gnt_o[k] = hs && (sel == IdxW'(k));
    end
  end

  // Credit bookkeeping: a weight of 0 behaves like 1; cb+1 is one bit wider.
  always_comb begin
    cb        = (sel == ptr) ? credit : '0;
    cb_inc    = {1'b0, cb} + 1'b1;
    w_eff     = (sel_weight == '0) ? (WeightWidth+1)'(1) : {1'b0, sel_weight};
    ptr_after = (sel == IdxW'(NumIn-1)) ? '0 : sel + 1'b1;
  end

  // Pointer, credit and lock state; reset beats flush, flush beats a handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ptr       <= '0;
      credit    <= '0;
      fsm_state <= IDLE;
      lock_idx  <= '0;
    end else begin
      if (hs) begin
        if (cb_inc < w_eff) begin
          ptr    <= sel;
          credit <= cb_inc[WeightWidth-1:0];
        end else begin
          ptr    <= ptr_after;
          credit <= '0;
        end
      end
      if (LockIn && req_o && !gnt_i) begin
        fsm_state <= LOCKED;
        lock_idx  <= sel;
      end else begin
        fsm_state <= IDLE;
      end
    end
  end

  // A locked requester withdrawing before its transfer is a protocol error.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && fsm_state == LOCKED) begin
      assert (req_i[lock_idx])
        else $error("locked requester %0d dropped req before handshake", lock_idx);
    end
  end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter (NumIn=4, DataWidth=32, WeightWidth=4).
// Inputs change 1 ns after the rising edge, and outputs are checked 3 ns later.
module tb_weighted_rr_arbiter;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic [NI-1:0]     req_i;
  logic [NI*DW-1:0]  data_i;
  logic [NI*WW-1:0]  weight_i;
  logic              gnt_i;
  logic [NI-1:0]     gnt_o;
  logic              req_o;
  logic [DW-1:0]     data_o;
  logic [1:0]        idx_o;

  int total = 0;
  int bad   = 0;

  weighted_rr_arbiter #(
    .NumIn(NI), .DataWidth(DW), .WeightWidth(WW), .LockIn(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .req_i(req_i),
    .data_i(data_i), .weight_i(weight_i), .gnt_i(gnt_i), .gnt_o(gnt_o),
    .req_o(req_o), .data_o(data_o), .idx_o(idx_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // let combinational outputs settle, away from the edge
  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // one flush cycle to put the arbiter back at ptr=0, credit=0, IDLE
  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  int          exp_idx;
  logic [3:0]  one_hot;
  int          wseq [10] = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0};

  initial begin
    data_i   = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    flush_i  = 1'b0;
    gnt_i    = 1'b1;
    req_i    = 4'b1111;

    // reset for two cycles while everyone requests
    rst_i = 1'b1;
    @(posedge clk_i);
    tick();
    rst_i = 1'b0;
    settle();
    chk("rst_req_o", 32'(req_o), 32'd1);
    chk("rst_idx",   32'(idx_o), 32'd0);
    chk("rst_gnt",   32'(gnt_o), 32'b0001);
    chk("rst_data",  data_o,     32'hDDDD_0000);

    // plain round robin, weights all 1
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        tick();
        settle();
      end
      exp_idx = i % 4;
      one_hot = 4'b0001 << exp_idx;
      chk("rr_idx", 32'(idx_o), 32'(exp_idx));
      chk("rr_gnt", 32'(gnt_o), 32'(one_hot));
    end
    tick();

    // nobody requests: every output is zero
    req_i = 4'b0000;
    settle();
    chk("idle_req_o", 32'(req_o), 32'd0);
    chk("idle_gnt",   32'(gnt_o), 32'd0);
    chk("idle_data",  data_o,     32'd0);
    chk("idle_idx",   32'(idx_o), 32'd0);
    tick();

    // weighted: weights {3,1,0,2} for inputs 0..3
    weight_i = {4'd2, 4'd0, 4'd1, 4'd3};
    req_i    = 4'b1111;
    flush_i  = 1'b1;
    settle();
    chk("flush_req_o", 32'(req_o), 32'd0);
    chk("flush_gnt",   32'(gnt_o), 32'd0);
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      settle();
      chk("wt_idx", 32'(idx_o), 32'(wseq[i]));
    end
    tick();

    // lock under back-pressure
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    do_flush();
    req_i = 4'b0110;
    gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      settle();
      chk("lock_idx",   32'(idx_o), 32'd1);
      chk("lock_data",  data_o,     32'hDDDD_0001);
      chk("lock_gnt",   32'(gnt_o), 32'd0);
      chk("lock_req_o", 32'(req_o), 32'd1);
    end
    // input 0 arrives while locked: selection must not move
    tick();
    req_i = 4'b0111;
    settle();
    chk("lock_hold_idx", 32'(idx_o), 32'd1);
    tick();
    gnt_i = 1'b1;
    settle();
    chk("lock_rel_idx", 32'(idx_o), 32'd1);
    chk("lock_rel_gnt", 32'(gnt_o), 32'b0010);
    tick();
    settle();
    chk("lock_next_idx", 32'(idx_o), 32'd2);
    chk("lock_next_gnt", 32'(gnt_o), 32'b0100);
    tick();

    // sparse requests with wrap-around from ptr=3
    do_flush();
    req_i = 4'b0100;
    settle();
    chk("sp_setup_idx", 32'(idx_o), 32'd2);
    tick();
    req_i = 4'b0101;
    settle();
    chk("sp_wrap_idx", 32'(idx_o), 32'd0);
    chk("sp_wrap_gnt", 32'(gnt_o), 32'b0001);
    tick();
    settle();
    chk("sp_next_idx", 32'(idx_o), 32'd2);
    chk("sp_next_gnt", 32'(gnt_o), 32'b0100);
    tick();

    // flush while locked on input 2
    do_flush();
    req_i = 4'b0100;
    gnt_i = 1'b0;
    settle();
    chk("fl_lock_idx", 32'(idx_o), 32'd2);
    tick();
    flush_i = 1'b1;
    settle();
    chk("fl_req_o", 32'(req_o), 32'd0);
    chk("fl_gnt",   32'(gnt_o), 32'd0);
    tick();
    flush_i = 1'b0;
    req_i   = 4'b1100;
    gnt_i   = 1'b1;
    settle();
    chk("fl_after_idx", 32'(idx_o), 32'd2);
    chk("fl_after_gnt", 32'(gnt_o), 32'b0100);
    tick();
    settle();
    chk("fl_after2_idx", 32'(idx_o), 32'd3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
